// File: rtl/axis_demux_pcp.sv
// Packet-level 1:16 AXI4-Stream demultiplexer with one shared output register.
// The destination is latched from a one-hot select on the first beat; packets with an invalid select are dropped.
module axis_demux_pcp #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m00_axis_tkeep,
    output logic                  m00_axis_tlast,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic [DATA_WIDTH-1:0] m01_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m01_axis_tkeep,
    output logic                  m01_axis_tlast,
    output logic                  m01_axis_tvalid,
    input  logic                  m01_axis_tready,
    output logic [DATA_WIDTH-1:0] m02_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m02_axis_tkeep,
    output logic                  m02_axis_tlast,
    output logic                  m02_axis_tvalid,
    input  logic                  m02_axis_tready,
    output logic [DATA_WIDTH-1:0] m03_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m03_axis_tkeep,
    output logic                  m03_axis_tlast,
    output logic                  m03_axis_tvalid,
    input  logic                  m03_axis_tready,
    output logic [DATA_WIDTH-1:0] m04_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m04_axis_tkeep,
    output logic                  m04_axis_tlast,
    output logic                  m04_axis_tvalid,
    input  logic                  m04_axis_tready,
    output logic [DATA_WIDTH-1:0] m05_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m05_axis_tkeep,
    output logic                  m05_axis_tlast,
    output logic                  m05_axis_tvalid,
    input  logic                  m05_axis_tready,
    output logic [DATA_WIDTH-1:0] m06_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m06_axis_tkeep,
    output logic                  m06_axis_tlast,
    output logic                  m06_axis_tvalid,
    input  logic                  m06_axis_tready,
    output logic [DATA_WIDTH-1:0] m07_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m07_axis_tkeep,
    output logic                  m07_axis_tlast,
    output logic                  m07_axis_tvalid,
    input  logic                  m07_axis_tready,
    output logic [DATA_WIDTH-1:0] m08_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m08_axis_tkeep,
    output logic                  m08_axis_tlast,
    output logic                  m08_axis_tvalid,
    input  logic                  m08_axis_tready,
    output logic [DATA_WIDTH-1:0] m09_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m09_axis_tkeep,
    output logic                  m09_axis_tlast,
    output logic                  m09_axis_tvalid,
    input  logic                  m09_axis_tready,
    output logic [DATA_WIDTH-1:0] m10_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m10_axis_tkeep,
    output logic                  m10_axis_tlast,
    output logic                  m10_axis_tvalid,
    input  logic                  m10_axis_tready,
    output logic [DATA_WIDTH-1:0] m11_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m11_axis_tkeep,
    output logic                  m11_axis_tlast,
    output logic                  m11_axis_tvalid,
    input  logic                  m11_axis_tready,
    output logic [DATA_WIDTH-1:0] m12_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m12_axis_tkeep,
    output logic                  m12_axis_tlast,
    output logic                  m12_axis_tvalid,
    input  logic                  m12_axis_tready,
    output logic [DATA_WIDTH-1:0] m13_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m13_axis_tkeep,
    output logic                  m13_axis_tlast,
    output logic                  m13_axis_tvalid,
    input  logic                  m13_axis_tready,
    output logic [DATA_WIDTH-1:0] m14_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m14_axis_tkeep,
    output logic                  m14_axis_tlast,
    output logic                  m14_axis_tvalid,
    input  logic                  m14_axis_tready,
    output logic [DATA_WIDTH-1:0] m15_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m15_axis_tkeep,
    output logic                  m15_axis_tlast,
    output logic                  m15_axis_tvalid,
    input  logic                  m15_axis_tready,
    input  logic                  sel_00,
    input  logic                  sel_01,
    input  logic                  sel_02,
    input  logic                  sel_03,
    input  logic                  sel_04,
    input  logic                  sel_05,
    input  logic                  sel_06,
    input  logic                  sel_07,
    input  logic                  sel_08,
    input  logic                  sel_09,
    input  logic                  sel_10,
    input  logic                  sel_11,
    input  logic                  sel_12,
    input  logic                  sel_13,
    input  logic                  sel_14,
    input  logic                  sel_15,
    output logic                  pkt_drop,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t                state;
    logic                  out_vld;
    logic [3:0]            out_dest;
    logic [DATA_WIDTH-1:0] out_data;
    logic [KEEP_WIDTH-1:0] out_keep;
    logic                  out_last;

    logic [15:0] sel;
    logic [15:0] tready_vec;
    logic [15:0] tvalid_vec;
    logic [3:0]  sel_idx;
    logic        sel_ok;
    logic        out_rdy;
    logic        accept;
    logic        load;

    assign sel = {sel_15, sel_14, sel_13, sel_12, sel_11, sel_10, sel_09, sel_08,
                  sel_07, sel_06, sel_05, sel_04, sel_03, sel_02, sel_01, sel_00};
    assign tready_vec = {m15_axis_tready, m14_axis_tready, m13_axis_tready, m12_axis_tready,
                         m11_axis_tready, m10_axis_tready, m09_axis_tready, m08_axis_tready,
                         m07_axis_tready, m06_axis_tready, m05_axis_tready, m04_axis_tready,
                         m03_axis_tready, m02_axis_tready, m01_axis_tready, m00_axis_tready};

    // A select is usable only with exactly one bit set.
    assign sel_ok = (sel != 16'd0) && ((sel & (sel - 16'd1)) == 16'd0);

    always_comb begin
        sel_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (sel[i]) sel_idx = 4'(i);
        end
    end

    always_comb begin
        tvalid_vec = 16'd0;
        for (int i = 0; i < 16; i++) begin
            tvalid_vec[i] = out_vld && (out_dest == 4'(i));
        end
    end

    assign out_rdy = tready_vec[out_dest];

    // Gated by rst so the input looks not-ready for the whole reset window.
    assign s_axis_tready = rst && (((state == IDLE) && !sel_ok) || (state == DROP) ||
                                   !out_vld || out_rdy);
    assign accept   = s_axis_tvalid && s_axis_tready;
    assign load     = accept && (((state == IDLE) && sel_ok) || (state == PASS));
    assign pkt_drop = accept && (state == IDLE) && !sel_ok;
    assign busy     = (state != IDLE) || out_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            out_vld  <= 1'b0;
            out_dest <= 4'd0;
            out_data <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
        end else begin
            if (load) begin
                out_vld  <= 1'b1;
                out_data <= s_axis_tdata;
                out_keep <= s_axis_tkeep;
                out_last <= s_axis_tlast;
                if (state == IDLE) out_dest <= sel_idx;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end

            if (accept) begin
                case (state)
                    IDLE:    state <= s_axis_tlast ? IDLE : (sel_ok ? PASS : DROP);
                    PASS:    if (s_axis_tlast) state <= IDLE;
                    DROP:    if (s_axis_tlast) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign m00_axis_tdata = out_data; assign m00_axis_tkeep = out_keep; assign m00_axis_tlast = out_last; assign m00_axis_tvalid = tvalid_vec[0];
    assign m01_axis_tdata = out_data; assign m01_axis_tkeep = out_keep; assign m01_axis_tlast = out_last; assign m01_axis_tvalid = tvalid_vec[1];
    assign m02_axis_tdata = out_data; assign m02_axis_tkeep = out_keep; assign m02_axis_tlast = out_last; assign m02_axis_tvalid = tvalid_vec[2];
    assign m03_axis_tdata = out_data; assign m03_axis_tkeep = out_keep; assign m03_axis_tlast = out_last; assign m03_axis_tvalid = tvalid_vec[3];
    assign m04_axis_tdata = out_data; assign m04_axis_tkeep = out_keep; assign m04_axis_tlast = out_last; assign m04_axis_tvalid = tvalid_vec[4];
    assign m05_axis_tdata = out_data; assign m05_axis_tkeep = out_keep; assign m05_axis_tlast = out_last; assign m05_axis_tvalid = tvalid_vec[5];
    assign m06_axis_tdata = out_data; assign m06_axis_tkeep = out_keep; assign m06_axis_tlast = out_last; assign m06_axis_tvalid = tvalid_vec[6];
    assign m07_axis_tdata = out_data; assign m07_axis_tkeep = out_keep; assign m07_axis_tlast = out_last; assign m07_axis_tvalid = tvalid_vec[7];
    assign m08_axis_tdata = out_data; assign m08_axis_tkeep = out_keep; assign m08_axis_tlast = out_last; assign m08_axis_tvalid = tvalid_vec[8];
    assign m09_axis_tdata = out_data; assign m09_axis_tkeep = out_keep; assign m09_axis_tlast = out_last; assign m09_axis_tvalid = tvalid_vec[9];
    assign m10_axis_tdata = out_data; assign m10_axis_tkeep = out_keep; assign m10_axis_tlast = out_last; assign m10_axis_tvalid = tvalid_vec[10];
    assign m11_axis_tdata = out_data; assign m11_axis_tkeep = out_keep; assign m11_axis_tlast = out_last; assign m11_axis_tvalid = tvalid_vec[11];
    assign m12_axis_tdata = out_data; assign m12_axis_tkeep = out_keep; assign m12_axis_tlast = out_last; assign m12_axis_tvalid = tvalid_vec[12];
    assign m13_axis_tdata = out_data; assign m13_axis_tkeep = out_keep; assign m13_axis_tlast = out_last; assign m13_axis_tvalid = tvalid_vec[13];
    assign m14_axis_tdata = out_data; assign m14_axis_tkeep = out_keep; assign m14_axis_tlast = out_last; assign m14_axis_tvalid = tvalid_vec[14];
    assign m15_axis_tdata = out_data; assign m15_axis_tkeep = out_keep; assign m15_axis_tlast = out_last; assign m15_axis_tvalid = tvalid_vec[15];

endmodule

// File: tb/tb_axis_demux_pcp.sv
// Bench for axis_demux_pcp: directed scenarios plus random packets, scored against per-port expected-beat queues.
module tb_axis_demux_pcp;

    localparam int DW = 128;
    localparam int KW = DW / 8;
    localparam int BW = DW + KW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    wire           s_tready;
    wire  [DW-1:0] m_tdata [16];
    wire  [KW-1:0] m_tkeep [16];
    wire  [15:0]   m_tlast;
    wire  [15:0]   m_tvalid;
    logic [15:0]   m_tready;
    logic [15:0]   sel;
    wire           pkt_drop;
    wire           busy;

    int check_cnt = 0;
    int fail_cnt  = 0;
    int drop_pulses = 0;
    int rdy_mode = 0;
    int bp_idx = 0;
    logic [3:0] bp_pat = 4'b1001;

    logic [BW-1:0] exp_q [16][$];
    logic          in_pkt = 1'b0;
    logic          drop_pkt = 1'b0;
    int            cur_dest = 0;

    always #5 clk = ~clk;

    axis_demux_pcp #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m00_axis_tdata(m_tdata[0]),  .m00_axis_tkeep(m_tkeep[0]),  .m00_axis_tlast(m_tlast[0]),  .m00_axis_tvalid(m_tvalid[0]),  .m00_axis_tready(m_tready[0]),
        .m01_axis_tdata(m_tdata[1]),  .m01_axis_tkeep(m_tkeep[1]),  .m01_axis_tlast(m_tlast[1]),  .m01_axis_tvalid(m_tvalid[1]),  .m01_axis_tready(m_tready[1]),
        .m02_axis_tdata(m_tdata[2]),  .m02_axis_tkeep(m_tkeep[2]),  .m02_axis_tlast(m_tlast[2]),  .m02_axis_tvalid(m_tvalid[2]),  .m02_axis_tready(m_tready[2]),
        .m03_axis_tdata(m_tdata[3]),  .m03_axis_tkeep(m_tkeep[3]),  .m03_axis_tlast(m_tlast[3]),  .m03_axis_tvalid(m_tvalid[3]),  .m03_axis_tready(m_tready[3]),
        .m04_axis_tdata(m_tdata[4]),  .m04_axis_tkeep(m_tkeep[4]),  .m04_axis_tlast(m_tlast[4]),  .m04_axis_tvalid(m_tvalid[4]),  .m04_axis_tready(m_tready[4]),
        .m05_axis_tdata(m_tdata[5]),  .m05_axis_tkeep(m_tkeep[5]),  .m05_axis_tlast(m_tlast[5]),  .m05_axis_tvalid(m_tvalid[5]),  .m05_axis_tready(m_tready[5]),
        .m06_axis_tdata(m_tdata[6]),  .m06_axis_tkeep(m_tkeep[6]),  .m06_axis_tlast(m_tlast[6]),  .m06_axis_tvalid(m_tvalid[6]),  .m06_axis_tready(m_tready[6]),
        .m07_axis_tdata(m_tdata[7]),  .m07_axis_tkeep(m_tkeep[7]),  .m07_axis_tlast(m_tlast[7]),  .m07_axis_tvalid(m_tvalid[7]),  .m07_axis_tready(m_tready[7]),
        .m08_axis_tdata(m_tdata[8]),  .m08_axis_tkeep(m_tkeep[8]),  .m08_axis_tlast(m_tlast[8]),  .m08_axis_tvalid(m_tvalid[8]),  .m08_axis_tready(m_tready[8]),
        .m09_axis_tdata(m_tdata[9]),  .m09_axis_tkeep(m_tkeep[9]),  .m09_axis_tlast(m_tlast[9]),  .m09_axis_tvalid(m_tvalid[9]),  .m09_axis_tready(m_tready[9]),
        .m10_axis_tdata(m_tdata[10]), .m10_axis_tkeep(m_tkeep[10]), .m10_axis_tlast(m_tlast[10]), .m10_axis_tvalid(m_tvalid[10]), .m10_axis_tready(m_tready[10]),
        .m11_axis_tdata(m_tdata[11]), .m11_axis_tkeep(m_tkeep[11]), .m11_axis_tlast(m_tlast[11]), .m11_axis_tvalid(m_tvalid[11]), .m11_axis_tready(m_tready[11]),
        .m12_axis_tdata(m_tdata[12]), .m12_axis_tkeep(m_tkeep[12]), .m12_axis_tlast(m_tlast[12]), .m12_axis_tvalid(m_tvalid[12]), .m12_axis_tready(m_tready[12]),
        .m13_axis_tdata(m_tdata[13]), .m13_axis_tkeep(m_tkeep[13]), .m13_axis_tlast(m_tlast[13]), .m13_axis_tvalid(m_tvalid[13]), .m13_axis_tready(m_tready[13]),
        .m14_axis_tdata(m_tdata[14]), .m14_axis_tkeep(m_tkeep[14]), .m14_axis_tlast(m_tlast[14]), .m14_axis_tvalid(m_tvalid[14]), .m14_axis_tready(m_tready[14]),
        .m15_axis_tdata(m_tdata[15]), .m15_axis_tkeep(m_tkeep[15]), .m15_axis_tlast(m_tlast[15]), .m15_axis_tvalid(m_tvalid[15]), .m15_axis_tready(m_tready[15]),
        .sel_00(sel[0]),  .sel_01(sel[1]),  .sel_02(sel[2]),  .sel_03(sel[3]),
        .sel_04(sel[4]),  .sel_05(sel[5]),  .sel_06(sel[6]),  .sel_07(sel[7]),
        .sel_08(sel[8]),  .sel_09(sel[9]),  .sel_10(sel[10]), .sel_11(sel[11]),
        .sel_12(sel[12]), .sel_13(sel[13]), .sel_14(sel[14]), .sel_15(sel[15]),
        .pkt_drop(pkt_drop), .busy(busy)
    );

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int queued_total();
        int n = 0;
        for (int p = 0; p < 16; p++) n += exp_q[p].size();
        return n;
    endfunction

    // Downstream ready generator: all ready, random, or the 1,0,0,1 pattern on port 7.
    initial begin
        m_tready = '0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_tready = '1;
                1: m_tready = 16'($urandom);
                default: begin
                    m_tready = '1;
                    m_tready[7] = bp_pat[bp_idx];
                    bp_idx = (bp_idx + 1) % 4;
                end
            endcase
        end
    end

    // Reference model: a packet goes whole to the port named by a one-hot select, else vanishes.
    always @(negedge clk) begin
        logic [15:0] exp_v;
        logic        onehot;
        logic        exp_rdy;
        int          idx;
        onehot = ($countones(sel) == 1);
        idx = 0;
        for (int p = 0; p < 16; p++) if (sel[p]) idx = p;
        if (!rst) begin
            check("rst_mvalid", BW'(m_tvalid), '0);
            check("rst_s_tready", BW'(s_tready), '0);
            check("rst_busy", BW'(busy), '0);
            check("rst_pkt_drop", BW'(pkt_drop), '0);
            for (int p = 0; p < 16; p++) exp_q[p].delete();
            in_pkt = 1'b0;
            drop_pkt = 1'b0;
        end else begin
            for (int p = 0; p < 16; p++) exp_v[p] = (exp_q[p].size() != 0);
            check("mvalid", BW'(m_tvalid), BW'(exp_v));
            check("busy", BW'(busy), BW'(in_pkt || (exp_v != 16'd0)));
            exp_rdy = (!in_pkt && !onehot) || (in_pkt && drop_pkt) || (exp_v == 16'd0) ||
                      ((exp_v & m_tready) != 16'd0);
            check("s_tready", BW'(s_tready), BW'(exp_rdy));
            check("pkt_drop", BW'(pkt_drop), BW'(!in_pkt && s_tvalid && !onehot));
            if (pkt_drop) drop_pulses++;
            for (int p = 0; p < 16; p++) begin
                if (exp_v[p] && m_tvalid[p]) begin
                    check($sformatf("m%0d_beat", p), {m_tdata[p], m_tkeep[p], m_tlast[p]}, exp_q[p][0]);
                    if (m_tready[p]) void'(exp_q[p].pop_front());
                end
            end
            if (s_tvalid && s_tready) begin
                if (!in_pkt) begin
                    drop_pkt = !onehot;
                    cur_dest = idx;
                end
                if (!drop_pkt) exp_q[cur_dest].push_back({s_tdata, s_tkeep, s_tlast});
                in_pkt = !s_tlast;
            end
        end
    end

    task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                              input logic [15:0] s, output int stalls);
        s_tdata = d; s_tkeep = k; s_tlast = l; sel = s; s_tvalid = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            stalls++;
            if (stalls > 500) begin
                check("accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    // Sends a packet; sel only matters on beat 0 and is scrambled afterwards.
    task automatic send_pkt(input logic [15:0] s, input int len, input int base, input bit rand_data,
                            input int abort_after, output int stalls);
        int st;
        logic [DW-1:0] d;
        stalls = 0;
        for (int b = 0; b < len; b++) begin
            if (b == abort_after) break;
            d = rand_data ? {$urandom, $urandom, $urandom, $urandom} : DW'(base + b);
            drive_beat(d, rand_data ? KW'($urandom) : '1, (b == len - 1),
                       (b == 0) ? s : 16'($urandom), st);
            stalls += st;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int st, st2, d0;
        logic [15:0] s;
        rst = 1'b0;
        s_tvalid = 1'b1; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; sel = 16'h0020;
        #1;
        check("rst_now_tready", BW'(s_tready), '0);
        idle_cycles(3);
        s_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("post_rst_tready", BW'(s_tready), BW'(1'b1));
        check("post_rst_busy", BW'(busy), '0);

        // Route: 4 beats, data 1..4 to port 5.
        send_pkt(16'h0020, 4, 1, 1'b0, -1, st);
        check("route_no_stall", BW'(st), '0);
        idle_cycles(3);

        // Back-to-back to ports 3 and 12.
        send_pkt(16'h0008, 4, 16'h30, 1'b0, -1, st);
        send_pkt(16'h1000, 3, 16'hc0, 1'b0, -1, st2);
        check("b2b_no_stall", BW'(st + st2), '0);
        idle_cycles(3);

        // Backpressure on port 7.
        rdy_mode = 2;
        send_pkt(16'h0080, 6, 16'h70, 1'b0, -1, st);
        idle_cycles(6);
        rdy_mode = 0;
        idle_cycles(2);

        // Drop: zero select and two-hot select.
        d0 = drop_pulses;
        send_pkt(16'h0000, 3, 16'hd0, 1'b0, -1, st);
        send_pkt(16'h0011, 3, 16'hd8, 1'b0, -1, st2);
        check("drop_no_stall", BW'(st + st2), '0);
        idle_cycles(2);
        check("drop_pulses", BW'(drop_pulses - d0), BW'(2));

        // Single-beat packets, including one dropped.
        send_pkt(16'h0001, 1, 16'h11, 1'b0, -1, st);
        send_pkt(16'h0000, 1, 16'h12, 1'b0, -1, st);
        send_pkt(16'h8000, 1, 16'h13, 1'b0, -1, st);
        idle_cycles(3);

        // Reset after beat 2 of 5 to port 9.
        rdy_mode = 2;
        send_pkt(16'h0200, 5, 16'h90, 1'b0, 2, st);
        rdy_mode = 3;
        m_tready = '0;
        #1;
        rst = 1'b0;
        #1;
        check("midrst_m09_tvalid", BW'(m_tvalid[9]), '0);
        check("midrst_busy", BW'(busy), '0);
        idle_cycles(2);
        rdy_mode = 0;
        rst = 1'b1;
        send_pkt(16'h0002, 3, 16'h10, 1'b0, -1, st);
        idle_cycles(3);

        // Random traffic with random downstream readiness.
        rdy_mode = 1;
        for (int n = 0; n < 80; n++) begin
            s = ($urandom_range(9, 0) < 8) ? (16'd1 << $urandom_range(15, 0)) : 16'($urandom);
            send_pkt(s, $urandom_range(6, 1), 0, 1'b1, -1, st);
            if ($urandom_range(3, 0) == 0) idle_cycles($urandom_range(3, 1));
        end
        rdy_mode = 0;
        idle_cycles(6);
        check("final_drain", BW'(queued_total()), '0);
        check("final_busy", BW'(busy), '0);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
